// File: rtl/synth_pkg.sv
// Shared register-write field layout, parameter codes and the queued request payload.
package synth_pkg;

    localparam int unsigned REQ_NUMBER_W     = 15;
    localparam int unsigned REQ_DATA_W       = 16;

    localparam int unsigned TABLE_SELECT_BIT = 14;
    localparam int unsigned PARAM_MSB        = 13;
    localparam int unsigned PARAM_LSB        = 8;
    localparam int unsigned VOICE_ADDR_W     = 8;
    localparam int unsigned TABLE_ADDR_W     = 14;

    localparam logic [5:0] PARAM_PHASE_STEP = 6'h00;
    localparam logic [5:0] ALGORITHM        = 6'h01;
    localparam logic [5:0] ATTACK_LEVEL     = 6'h02;
    localparam logic [5:0] SUSTAIN_LEVEL    = 6'h03;
    localparam logic [5:0] ATTACK_RATE      = 6'h04;
    localparam logic [5:0] DECAY_RATE       = 6'h05;
    localparam logic [5:0] RELEASE_RATE     = 6'h06;
    localparam logic [5:0] FEEDBACK_LEVEL   = 6'h07;
    localparam logic [5:0] NOTE_ON0         = 6'h10;
    localparam logic [5:0] NOTE_ON1         = 6'h11;
    localparam logic [5:0] LED_CONFIG       = 6'h12;

    typedef struct packed {
        logic [REQ_NUMBER_W-1:0] number;
        logic [REQ_DATA_W-1:0]   value;
    } write_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push into a full FIFO is honoured only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/reg_write_dispatch.sv
// Turns the SPI level write strobe into queued write transactions and dispatches each,
// in order, to a parameter, table or global-register target.
module reg_write_dispatch
    import synth_pkg::*;
#(
    parameter int unsigned NUMBER_WIDTH    = 15,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned NUM_PARAMS      = 19,
    parameter int unsigned GLOBAL_BASE     = 32,
    parameter int unsigned NUM_GLOBAL_REGS = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                  i_Clock,
    input  logic                                  i_Reset_n,
    input  logic                                  i_WriteEnable,
    input  logic [NUMBER_WIDTH-1:0]               i_WriteNumber,
    input  logic [DATA_WIDTH-1:0]                 i_WriteValue,
    input  logic                                  i_TableReady,
    input  logic                                  i_ClearErrors,
    output logic [NUM_PARAMS-1:0]                 o_ParamWriteEnable,
    output logic [VOICE_ADDR_W-1:0]               o_ParamWriteAddr,
    output logic                                  o_TableWriteEnable,
    output logic [TABLE_ADDR_W-1:0]               o_TableWriteAddr,
    output logic [DATA_WIDTH-1:0]                 o_WriteData,
    output logic [NUM_GLOBAL_REGS*DATA_WIDTH-1:0] o_GlobalRegs,
    output logic                                  o_Busy,
    output logic                                  o_Overflow,
    output logic                                  o_DecodeError
);

    localparam int unsigned REQ_W = $bits(write_req_t);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                       strobe_hist;
    logic                       new_req;
    write_req_t                 in_req;
    write_req_t                 head;
    logic [REQ_W-1:0]           head_bits;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    logic                       pop;

    logic [PARAM_MSB-PARAM_LSB:0] code;
    int unsigned                  code_u;
    logic                         is_table;
    logic                         is_param;
    logic                         is_global;
    logic                         is_bad;

    logic [DATA_WIDTH-1:0]        global_regs [NUM_GLOBAL_REGS];

    // History resets high so a strobe already asserted at reset release is ignored.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) strobe_hist <= 1'b1;
        else            strobe_hist <= i_WriteEnable;
    end

    assign new_req       = i_WriteEnable & ~strobe_hist;
    assign in_req.number = i_WriteNumber;
    assign in_req.value  = i_WriteValue;
    assign head          = write_req_t'(head_bits);

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .push  (new_req),
        .pop   (pop),
        .wdata (in_req),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A table head waits for the target; everything behind it waits too.
    assign pop    = ~fifo_empty & (~head.number[TABLE_SELECT_BIT] | i_TableReady);
    assign o_Busy = (fifo_count != '0);

    always_comb begin
        code      = head.number[PARAM_MSB:PARAM_LSB];
        code_u    = 32'(code);
        is_table  = head.number[TABLE_SELECT_BIT];
        is_param  = ~is_table && (code_u < NUM_PARAMS);
        is_global = ~is_table && (code_u >= GLOBAL_BASE) &&
                    (code_u < GLOBAL_BASE + NUM_GLOBAL_REGS);
        is_bad    = ~is_table & ~is_param & ~is_global;
    end

    // Dispatch outputs are single-cycle: cleared every edge, set only on a pop.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_ParamWriteEnable <= '0;
            o_ParamWriteAddr   <= '0;
            o_TableWriteEnable <= 1'b0;
            o_TableWriteAddr   <= '0;
            o_WriteData        <= '0;
        end else begin
            o_ParamWriteEnable <= '0;
            o_ParamWriteAddr   <= '0;
            o_TableWriteEnable <= 1'b0;
            o_TableWriteAddr   <= '0;
            o_WriteData        <= '0;
            if (pop && is_table) begin
                o_TableWriteEnable <= 1'b1;
                o_TableWriteAddr   <= head.number[TABLE_ADDR_W-1:0];
                o_WriteData        <= head.value;
            end else if (pop && is_param) begin
                o_ParamWriteEnable <= NUM_PARAMS'(1) << code;
                o_ParamWriteAddr   <= head.number[VOICE_ADDR_W-1:0];
                o_WriteData        <= head.value;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int unsigned g = 0; g < NUM_GLOBAL_REGS; g++) global_regs[g] <= '0;
        end else if (pop && is_global) begin
            for (int unsigned g = 0; g < NUM_GLOBAL_REGS; g++) begin
                if (code_u == GLOBAL_BASE + g) global_regs[g] <= head.value;
            end
        end
    end

    always_comb begin
        o_GlobalRegs = '0;
        for (int unsigned g = 0; g < NUM_GLOBAL_REGS; g++) begin
            o_GlobalRegs[g*DATA_WIDTH +: DATA_WIDTH] = global_regs[g];
        end
    end

    // Sticky flags: a new event on the clear cycle keeps the flag set.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Overflow    <= 1'b0;
            o_DecodeError <= 1'b0;
        end else begin
            if (new_req && fifo_full && !pop) o_Overflow <= 1'b1;
            else if (i_ClearErrors)           o_Overflow <= 1'b0;
            if (pop && is_bad)                o_DecodeError <= 1'b1;
            else if (i_ClearErrors)           o_DecodeError <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_write_dispatch.sv
// Scoreboard bench for reg_write_dispatch: directed writes push expected pulses, a monitor checks them.
module tb_reg_write_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [14:0] num;
    logic [15:0] val;
    logic        ready;
    logic        clr;
    logic [18:0] pen;
    logic [7:0]  paddr;
    logic        ten;
    logic [13:0] taddr;
    logic [15:0] wdata;
    logic [63:0] gregs;
    logic        busy;
    logic        ovf;
    logic        derr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        bit is_table;
        int idx;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    logic [18:0] m_pen;
    int m_addr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_write_dispatch dut (
        .i_Clock            (clk),
        .i_Reset_n          (rst_n),
        .i_WriteEnable      (we),
        .i_WriteNumber      (num),
        .i_WriteValue       (val),
        .i_TableReady       (ready),
        .i_ClearErrors      (clr),
        .o_ParamWriteEnable (pen),
        .o_ParamWriteAddr   (paddr),
        .o_TableWriteEnable (ten),
        .o_TableWriteAddr   (taddr),
        .o_WriteData        (wdata),
        .o_GlobalRegs       (gregs),
        .o_Busy             (busy),
        .o_Overflow         (ovf),
        .o_DecodeError      (derr)
    );

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (ten || (pen != '0)) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d ten=%0b pen=%05h paddr=%02h taddr=%04h data=%04h",
                         cyc, ten, pen, paddr, taddr, wdata);
            end else begin
                m_e    = q.pop_front();
                m_pen  = m_e.is_table ? 19'd0 : (19'd1 << m_e.idx);
                m_addr = ten ? int'(taddr) : int'(paddr);
                if (ten !== m_e.is_table || pen !== m_pen || m_addr != m_e.addr ||
                    int'(wdata) != m_e.data || (m_e.cyc >= 0 && cyc != m_e.cyc)) begin
                    miscompares++;
                    $display("FAIL pulse actual: cyc=%0d ten=%0b pen=%05h addr=%04h data=%04h required: cyc=%0d ten=%0b pen=%05h addr=%04h data=%04h",
                             cyc, ten, pen, m_addr, wdata, m_e.cyc, m_e.is_table, m_pen, m_e.addr, m_e.data);
                end
            end
        end else if (rst_n && wdata != '0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_data cyc=%0d actual=%04h required=0000", cyc, wdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [14:0] n, input logic [15:0] v);
        num = n;
        val = v;
        we  = 1'b1;
        tick();
        we  = 1'b0;
        tick();
    endtask

    task automatic expect_pulse(input bit is_table, input int idx, input int addr, input int data, input int c);
        exp_t e;
        e.is_table = is_table;
        e.idx      = idx;
        e.addr     = addr;
        e.data     = data;
        e.cyc      = c;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(name, 64'((q.size() == 0) && !busy), 64'd1);
    endtask

    task automatic clear_flags;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        we    = 1'b1;
        num   = 15'h0001;
        val   = 16'h1234;
        ready = 1'b1;
        clr   = 1'b0;
        #23;
        check("rst_pen",   64'(pen),   64'd0);
        check("rst_ten",   64'(ten),   64'd0);
        check("rst_data",  64'(wdata), 64'd0);
        check("rst_gregs", gregs,      64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_flags", 64'({ovf, derr}), 64'd0);

        // Strobe held high through reset release must not fire.
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("held_strobe_busy", 64'(busy), 64'd0);
        we = 1'b0;
        tick();

        // Single rise, held 10 cycles: one pulse two edges after the rise.
        num = 15'h0005;
        val = 16'hBEEF;
        expect_pulse(1'b0, 0, 8'h05, 16'hBEEF, cyc + 2);
        we = 1'b1;
        repeat (10) tick();
        we = 1'b0;
        tick();
        drain("drain_single");

        // Stalled table head blocks the param write behind it.
        ready = 1'b0;
        wr(15'h4123, 16'h1111);
        wr(15'h0203, 16'h2222);
        repeat (3) tick();
        check("stall_busy", 64'(busy), 64'd1);
        expect_pulse(1'b1, 0, 14'h0123, 16'h1111, cyc + 1);
        expect_pulse(1'b0, 2, 8'h03,    16'h2222, cyc + 2);
        ready = 1'b1;
        drain("drain_stall");

        // Overflow: fifth write into a stalled, full FIFO is dropped.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(15'(16'h4010 + i), 16'(16'hA000 + i));
            expect_pulse(1'b1, 0, 16'h0010 + i, 16'hA000 + i, -1);
        end
        check("ovf_before", 64'(ovf), 64'd0);
        wr(15'h4020, 16'hDEAD);
        check("ovf_after", 64'(ovf), 64'd1);
        ready = 1'b1;
        drain("drain_ovf");
        check("ovf_sticky", 64'(ovf), 64'd1);
        clear_flags();
        check("ovf_cleared", 64'(ovf), 64'd0);

        // Global bank and decode boundaries.
        wr(15'h2100, 16'h0007);
        tick();
        check("greg1_field", 64'(gregs[31:16]), 64'h7);
        check("greg1_bank",  gregs, 64'h0000_0000_0007_0000);
        wr(15'h2300, 16'hA5A5);
        tick();
        check("greg3_bank",  gregs, 64'hA5A5_0000_0007_0000);
        check("global_no_derr", 64'(derr), 64'd0);
        expect_pulse(1'b0, 18, 8'h09, 16'h0042, -1);
        wr(15'h1209, 16'h0042);
        drain("drain_led");
        check("param18_no_derr", 64'(derr), 64'd0);
        wr(15'h3F00, 16'h1234);
        tick();
        check("derr_3f", 64'(derr), 64'd1);
        clear_flags();
        check("derr_cleared", 64'(derr), 64'd0);
        wr(15'h2400, 16'h5555);
        tick();
        check("derr_code36", 64'(derr), 64'd1);
        check("greg_unchanged", gregs, 64'hA5A5_0000_0007_0000);
        clear_flags();
        wr(15'h1300, 16'h0001);
        tick();
        check("derr_code19", 64'(derr), 64'd1);
        clear_flags();

        // Back-to-back rises every two cycles.
        for (int i = 0; i < 8; i++) begin
            expect_pulse(1'b0, i, 16'h10 + i, 16'h1000 + i, cyc + 2);
            wr(15'((i << 8) | (16'h10 + i)), 16'(16'h1000 + i));
        end
        drain("drain_burst");
        check("burst_no_ovf", 64'(ovf), 64'd0);

        // Reset with a pending entry discards it without a pulse.
        ready = 1'b0;
        wr(15'h4001, 16'h0009);
        check("pending_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        ready = 1'b1;
        rst_n = 1'b1;
        repeat (4) tick();
        check("reset_discard_busy", 64'(busy), 64'd0);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_dispatch.md
Name: reg_write_dispatch

Overview:
Successor to the inline SPI register-write decode in the synth top level. It turns the SPI block's level-type write strobe into single write transactions and buffers them in a parametrised FIFO. Each transaction is dispatched in order as a one-cycle enable pulse to a voice-operator parameter target, a table target (sine table), or an internal global register bank. The table target applies backpressure; overflows and undecodable writes are flagged with sticky bits.

Parameters:
NUMBER_WIDTH, 15, width of register number from SPI
DATA_WIDTH, 16, register value width
NUM_PARAMS, 19, count of voice-op parameter codes 0..NUM_PARAMS-1 with enable outputs
GLOBAL_BASE, 32, first 6-bit parameter code mapped to the global register bank
NUM_GLOBAL_REGS, 4, global registers (codes GLOBAL_BASE..GLOBAL_BASE+NUM_GLOBAL_REGS-1)
FIFO_DEPTH, 4, pending transactions (power of two, >=2)

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_WriteEnable  in  1  level write strobe from spi
i_WriteNumber  in  NUMBER_WIDTH  register number; bit14 table select, [13:8] param code, [7:0] voice/op address
i_WriteValue  in  DATA_WIDTH  register value
i_TableReady  in  1  table target can accept a write this cycle
i_ClearErrors  in  1  clears sticky flags
o_ParamWriteEnable  out  NUM_PARAMS  one-hot write pulse per parameter code
o_ParamWriteAddr  out  8  voice/op address for param write
o_TableWriteEnable  out  1  table write pulse
o_TableWriteAddr  out  14  table address
o_WriteData  out  DATA_WIDTH  value accompanying any pulse
o_GlobalRegs  out  NUM_GLOBAL_REGS*DATA_WIDTH  flattened global bank, reg 0 in LSBs
o_Busy  out  1  FIFO not empty
o_Overflow  out  1  sticky: write dropped because FIFO was full
o_DecodeError  out  1  sticky: param code matched no target

Behaviour:
- Reset (async assert, released synchronously to the design): FIFO empty; all pulses and outputs 0; global regs 0; flags 0; edge-detect history register = 1, so a strobe already high at reset release does not fire.
- Edge detect: new request when i_WriteEnable=1 and history=0 at a clock edge. History is updated every cycle.
- Enqueue: at edge k, {number, value} is pushed. If the FIFO is full and no pop occurs at edge k, the request is dropped and o_Overflow is set. If full with a pop at the same edge, the request is accepted.
- Pop eligibility: FIFO not empty, and either the head is not a table write or i_TableReady=1 at that edge. Strictly in order; a stalled table head blocks all later entries.
- Pop at edge k+1 registers the outputs for exactly one cycle. Minimum latency: request edge k to pulse high between k+1 and k+2. Throughput is 1 per cycle.
- Decode of the popped head:
  - bit14=1: o_TableWriteEnable=1, addr=[13:0].
  - code<NUM_PARAMS: o_ParamWriteEnable[code]=1, addr=[7:0].
  - GLOBAL_BASE<=code<GLOBAL_BASE+NUM_GLOBAL_REGS: global reg[code-GLOBAL_BASE] <= value at the pop edge; no pulse.
  - Otherwise: no pulse, o_DecodeError set.
- o_WriteData holds the popped value during a pulse and 0 otherwise. All pulse outputs are 0 in cycles with no pop.
- Sticky flags: a set on the same edge as i_ClearErrors wins.
- o_Busy is combinational from FIFO count.
- Reset mid-transaction discards pending entries; no pulse is emitted.

Decomposition:
- synth_pkg holds:
  - field constants TABLE_SELECT_BIT=14, PARAM_MSB=13, PARAM_LSB=8.
  - parameter codes PARAM_PHASE_STEP=0x00, ALGORITHM=0x01, ATTACK_LEVEL=0x02, SUSTAIN_LEVEL=0x03, ATTACK_RATE=0x04, DECAY_RATE=0x05, RELEASE_RATE=0x06, FEEDBACK_LEVEL=0x07, NOTE_ON0=0x10, NOTE_ON1=0x11, LED_CONFIG=0x12.
  - packed struct write_req_t {number, value}.
- Sub-module sync_fifo (parametrised width/depth, push/pop/full/empty/count, same async reset); decode and global bank stay in this module.

Test Plan:
- Strobe low->high with number 0x0005, value 0xBEEF, held 10 cycles -> exactly one o_ParamWriteEnable[0] pulse, addr 0x05, data 0xBEEF, 2 edges after the rise; no second pulse.
- Hold i_WriteEnable=1 through reset release -> no transaction; drop and re-raise strobe -> one transaction.
- i_TableReady=0, write 0x4123/0x1111 then 0x0203/0x2222 -> no pulses, o_Busy=1; raise ready -> table pulse addr 0x0123, then next cycle param[2] pulse addr 0x03.
- Ready held 0, 5 writes with FIFO_DEPTH=4 -> 5th dropped, o_Overflow=1; release -> 4 pulses only; i_ClearErrors -> flag 0.
- Write 0x2100 (code 33)/0x0007 -> o_GlobalRegs[31:16]=0x0007 after pop edge, no pulse; write 0x3F00 -> o_DecodeError=1, no pulse.
- Back-to-back rises every 2 cycles, 8 writes with ready=1 -> 8 pulses in order with matching data; no overflow.
